// File: rtl/rev_dot_mac.sv
// Purpose : unsigned dot-product MAC; each term is a WIDTH-cycle shift-add multiply, products summed with reversible ripple adders.
// Latency : accept edge T -> MUL edges T+1..T+WIDTH, ACC edge T+WIDTH+1 (result visible after it); one term per WIDTH+2 cycles.
// Backpress: in_ready is high only in IDLE; a pending result holds all outputs stable until out_ready is seen.
//
// Ports: clk/rst_n (async active-low), in_valid/in_ready/a/b/in_last term input,
//        out_valid/out_ready/out_acc/out_ovf result output (out_acc/out_ovf are zero while out_valid=0).

// Reversible 3-bit Toffoli: controls pass through, target flips when both controls are 1.
module toffoli_gate (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic q,
    output logic r
);
    assign p = a;
    assign q = b;
    assign r = c ^ (a & b);
endmodule

// Reversible full adder: first Toffoli forms x&y on a zero ancilla, CNOT forms x^y,
// second Toffoli folds (x^y)&cin into the ancilla. The two terms are mutually
// exclusive, so the XOR in the ancilla equals the carry. Pass-through outputs are garbage.
module rev_full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic g_and;
    logic x_xor_y;
    logic unused_p0, unused_q0, unused_p1, unused_q1;

    toffoli_gate u_t0 (.a(x), .b(y), .c(1'b0), .p(unused_p0), .q(unused_q0), .r(g_and));
    assign x_xor_y = x ^ y;
    toffoli_gate u_t1 (.a(x_xor_y), .b(cin), .c(g_and), .p(unused_p1), .q(unused_q1), .r(cout));
    assign s = x_xor_y ^ cin;
endmodule

// N-bit ripple-carry adder built from reversible full adders.
module rev_ripple_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] c;
    assign c[0] = 1'b0;
    for (genvar k = 0; k < N; k++) begin : g_bit
        rev_full_adder u_fa (.x(x[k]), .y(y[k]), .cin(c[k]), .s(s[k]), .cout(c[k+1]));
    end
    assign cout = c[N];
endmodule

module rev_dot_mac #(
    parameter int WIDTH = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = 2*WIDTH + ((LEN > 1) ? $clog2(LEN) : 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(LEN + 2);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               last_q;
    logic [IW-1:0]      i_q;
    logic [PW-1:0]      prod_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CW-1:0]      term_cnt_q;
    logic               ovf_sticky_q;

    // Shift-add step: addend is a<<i when b[i] is set, else zero.
    logic [PW-1:0]      addend;
    logic [PW-1:0]      prod_sum;
    logic               unused_prod_cout;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_cout;
    logic [CW-1:0]      term_nxt;
    logic               ovf_nxt;

    assign addend = b_q[i_q] ? ({{WIDTH{1'b0}}, a_q} << i_q) : '0;

    rev_ripple_add #(.N(PW)) u_prod_add (
        .x(prod_q), .y(addend), .s(prod_sum), .cout(unused_prod_cout)
    );

    rev_ripple_add #(.N(ACC_W)) u_acc_add (
        .x(acc_q), .y({{(ACC_W-PW){1'b0}}, prod_q}), .s(acc_sum), .cout(acc_cout)
    );

    // Term counter saturates at LEN+1 so "more than LEN" stays visible without wrapping.
    assign term_nxt = (term_cnt_q == CW'(LEN + 1)) ? term_cnt_q : term_cnt_q + 1'b1;
    assign ovf_nxt  = ovf_sticky_q | acc_cout | (term_nxt > CW'(LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL:  if (i_q == IW'(WIDTH - 1)) state_d = ACC;
            ACC:  state_d = last_q ? OUT : IDLE;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            last_q       <= 1'b0;
            i_q          <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            term_cnt_q   <= '0;
            ovf_sticky_q <= 1'b0;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_ovf      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q    <= a;
                    b_q    <= b;
                    last_q <= in_last;
                    prod_q <= '0;
                    i_q    <= '0;
                end
                MUL: begin
                    prod_q <= prod_sum;
                    i_q    <= i_q + 1'b1;
                end
                ACC: begin
                    acc_q        <= acc_sum;
                    term_cnt_q   <= term_nxt;
                    ovf_sticky_q <= ovf_nxt;
                    if (last_q) begin
                        out_valid <= 1'b1;
                        out_acc   <= acc_sum;
                        out_ovf   <= ovf_nxt;
                    end
                end
                OUT: if (out_ready) begin
                    acc_q        <= '0;
                    term_cnt_q   <= '0;
                    ovf_sticky_q <= 1'b0;
                    out_valid    <= 1'b0;
                    out_acc      <= '0;
                    out_ovf      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
